// File: rtl/vga_scanout.sv
// VGA scan-out: pixel-tick timing generator, framebuffer address stage and registered pin stage.
// Optional build macro VGA_SCANOUT_TEST_PATTERN_EN adds a test_mode input selecting 8 colour bars.
module vga_scanout #(
    parameter int CLK_DIV     = 4,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SCALE_SHIFT = 3,
    parameter int FB_ADDR_W   = 13
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [11:0]          fb_data,
    output logic                 hSync,
    output logic                 vSync,
    output logic [3:0]           VGA_R,
    output logic [3:0]           VGA_G,
    output logic [3:0]           VGA_B,
    output logic                 frame_start,
    output logic                 in_vblank
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_W      = $clog2(H_TOTAL);
    localparam int V_W      = $clog2(V_TOTAL);
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int FB_W     = H_VISIBLE >> SCALE_SHIFT;
    localparam int MUL_BITS = $clog2(FB_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_VIS    = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0]   HS_START = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0]   HS_END   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_VIS    = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0]   VS_START = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0]   VS_END   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [31:0]      FB_W_C   = 32'(FB_W);

    // Timing counters
    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [V_W-1:0]   v_q, v_d;
    logic             tick;

    // Stage A
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [FB_ADDR_W-1:0] row, col, row_base;
    logic                 visible;
    logic                 vis_a_q, hs_a_q, vs_a_q, hs_a_d, vs_a_d;
    logic                 frame_start_q, in_vblank_q;

    // Stage B
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, vsync_q;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Row base = row * FB_W as a constant shift-add over the set bits of FB_W.
    always_comb begin
        row      = FB_ADDR_W'(v_q >> SCALE_SHIFT);
        col      = FB_ADDR_W'(h_q >> SCALE_SHIFT);
        row_base = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (FB_W_C[i]) begin
                row_base = row_base + (row << i);
            end
        end
    end

    always_comb begin
        visible   = (h_q < H_VIS) && (v_q < V_VIS);
        fb_addr_d = visible ? (row_base + col) : fb_addr_q;
        hs_a_d    = !((h_q >= HS_START) && (h_q < HS_END));
        vs_a_d    = !((v_q >= VS_START) && (v_q < VS_END));
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam int BAR_W = H_VISIBLE / 8;
    logic [6:0] bar_ge;
    logic [2:0] bar_d, bar_a_q;

    // Bar index = number of bar boundaries already passed by h.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_bar
            assign bar_ge[gi] = (h_q >= H_W'((gi + 1) * BAR_W));
        end
    endgenerate

    always_comb begin
        bar_d = '0;
        for (int i = 0; i < 7; i++) begin
            bar_d = bar_d + {2'b00, bar_ge[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bar_a_q <= '0;
        end else if (tick) begin
            bar_a_q <= bar_d;
        end
    end

    always_comb begin
        rgb_d = vis_a_q ? fb_data : 12'h000;
        if (test_mode) begin
            rgb_d = vis_a_q ? {{4{bar_a_q[2]}}, {4{bar_a_q[1]}}, {4{bar_a_q[0]}}} : 12'h000;
        end
    end
`else
    always_comb begin
        rgb_d = vis_a_q ? fb_data : 12'h000;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            fb_addr_q     <= '0;
            vis_a_q       <= 1'b0;
            hs_a_q        <= 1'b1;
            vs_a_q        <= 1'b1;
            frame_start_q <= 1'b0;
            in_vblank_q   <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            // Not gated by tick so the pulse drops on the following clock.
            frame_start_q <= tick && (h_q == '0) && (v_q == '0);
            if (tick) begin
                fb_addr_q   <= fb_addr_d;
                vis_a_q     <= visible;
                hs_a_q      <= hs_a_d;
                vs_a_q      <= vs_a_d;
                in_vblank_q <= (v_q >= V_VIS);
                rgb_q       <= rgb_d;
                hsync_q     <= hs_a_q;
                vsync_q     <= vs_a_q;
            end
        end
    end

    assign fb_addr     = fb_addr_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign frame_start = frame_start_q;
    assign in_vblank   = in_vblank_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced 48x23-pixel raster; scoreboard of per-pixel pin values.
// Exercises the colour-bar path when VGA_SCANOUT_TEST_PATTERN_EN is defined.
module tb_vga_scanout;
    localparam int CLK_DIV = 4;
    localparam int H_VIS   = 32;
    localparam int H_FP    = 4;
    localparam int H_SY    = 8;
    localparam int H_BP    = 4;
    localparam int V_VIS   = 16;
    localparam int V_FP    = 2;
    localparam int V_SY    = 2;
    localparam int V_BP    = 3;
    localparam int S       = 2;
    localparam int AW      = 13;
    localparam int H_TOT   = H_VIS + H_FP + H_SY + H_BP;
    localparam int V_TOT   = V_VIS + V_FP + V_SY + V_BP;
    localparam int FBW     = H_VIS >> S;
    localparam int BAR_W   = H_VIS / 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          test_mode = 1'b0;
    logic [AW-1:0] fb_addr;
    logic [11:0]   fb_data = 12'h000;
    logic          hSync, vSync, frame_start, in_vblank;
    logic [3:0]    VGA_R, VGA_G, VGA_B;

    always #5 clock = ~clock;

    // Framebuffer model: texel equals its own address, one clock read latency.
    always_ff @(posedge clock) fb_data <= fb_addr[11:0];

    vga_scanout #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VIS), .H_FRONT(H_FP), .H_SYNC(H_SY), .H_BACK(H_BP),
        .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SY), .V_BACK(V_BP),
        .SCALE_SHIFT(S), .FB_ADDR_W(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .hSync(hSync),
        .vSync(vSync),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .frame_start(frame_start),
        .in_vblank(in_vblank)
    );

    typedef struct {
        logic        vis;
        logic [11:0] col;
        logic [11:0] bar;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t          sb_q[$];
    int            tests = 0;
    int            fails = 0;
    int            mh, mv, last_h, last_v;
    logic [AW-1:0] m_addr;
    int            clk_cnt, fs_cnt, hs_fall, hs_low0, vs_fall, vs_low0;
    logic          prev_hs, prev_vs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] bar_color(input int i);
        logic [2:0] b;
        b = 3'(i);
        return {b[2] ? 4'hF : 4'h0, b[1] ? 4'hF : 4'h0, b[0] ? 4'hF : 4'h0};
    endfunction

    task automatic model_init();
        sb_q.delete();
        sb_q.push_back('{vis: 1'b0, col: 12'h000, bar: 12'h000, hs: 1'b1, vs: 1'b1});
        mh = 0; mv = 0; last_h = -1; last_v = -1; m_addr = '0;
        fs_cnt = 0; hs_fall = -1; vs_fall = -1; hs_low0 = 0; vs_low0 = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1 reset = 1'b0;
        model_init();
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_hsync", 32'(hSync), 32'd1);
        check("rst_vsync", 32'(vSync), 32'd1);
        check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_in_vblank", 32'(in_vblank), 32'd0);
    endtask

    // Sync edge timing measured in clocks at every clock sample.
    task automatic monitor();
        clk_cnt++;
        if (frame_start) fs_cnt++;
        if (prev_hs && !hSync) begin
            if (hs_fall >= 0) check("h_period", 32'(clk_cnt - hs_fall), 32'(H_TOT * CLK_DIV));
            hs_fall = clk_cnt;
            hs_low0 = clk_cnt;
        end
        if (!prev_hs && hSync) check("h_low_len", 32'(clk_cnt - hs_low0), 32'(H_SY * CLK_DIV));
        if (prev_vs && !vSync) begin
            if (vs_fall >= 0) check("v_period", 32'(clk_cnt - vs_fall), 32'(V_TOT * H_TOT * CLK_DIV));
            vs_fall = clk_cnt;
            vs_low0 = clk_cnt;
        end
        if (!prev_vs && vSync) check("v_low_len", 32'(clk_cnt - vs_low0), 32'(V_SY * H_TOT * CLK_DIV));
        prev_hs = hSync;
        prev_vs = vSync;
    endtask

    task automatic step_pixel();
        exp_t        e, n;
        logic        vis;
        logic [11:0] exp_rgb;
        for (int c = 0; c < CLK_DIV; c++) begin
            @(posedge clock);
            #1;
            monitor();
            if (c < CLK_DIV - 1) check("fs_width", 32'(frame_start), 32'd0);
        end
        vis = (mh < H_VIS) && (mv < V_VIS);
        if (vis) m_addr = AW'((mv >> S) * FBW + (mh >> S));
        check("fb_addr", 32'(fb_addr), 32'(m_addr));
        check("frame_start", 32'(frame_start), 32'(mh == 0 && mv == 0));
        check("in_vblank", 32'(in_vblank), 32'(mv >= V_VIS));
        check("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            exp_rgb = !e.vis ? 12'h000 : (test_mode ? e.bar : e.col);
            check("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
            check("hsync", 32'(hSync), 32'(e.hs));
            check("vsync", 32'(vSync), 32'(e.vs));
        end
        n.vis = vis;
        n.col = m_addr[11:0];
        n.bar = bar_color(mh / BAR_W);
        n.hs  = !((mh >= H_VIS + H_FP) && (mh < H_VIS + H_FP + H_SY));
        n.vs  = !((mv >= V_VIS + V_FP) && (mv < V_VIS + V_FP + V_SY));
        sb_q.push_back(n);
        last_h = mh;
        last_v = mv;
        if (mh == H_TOT - 1) begin
            mh = 0;
            mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
    endtask

    task automatic run_until(input int x, input int y);
        int i;
        i = 0;
        while (!(last_h == x && last_v == y) && i < 3000) begin
            step_pixel();
            i++;
        end
        check("reach_pixel", 32'(last_h == x && last_v == y), 32'd1);
    endtask

    initial begin
        clk_cnt = 0;
        do_reset(3);

        // Two full frames from reset
        for (int p = 0; p < 2 * H_TOT * V_TOT; p++) step_pixel();
        $display("[TB] two frames scanned, frame_start pulses %0d", fs_cnt);
        check("fs_per_2frames", 32'(fs_cnt), 32'd2);

        // Block addressing: pixel (5,9) is texel row 2, column 1
        run_until(5, 9);
        check("blk_addr", 32'(fb_addr), 32'd17);
        step_pixel();
        check("blk_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd17);
        $display("[TB] block pixel (5,9) addr %0d", fb_addr);

        // Mid-frame reset aborts and restarts at (0,0)
        run_until(20, 10);
        do_reset(2);
        step_pixel();
        check("post_rst_hsync", 32'(hSync), 32'd1);
        check("post_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        $display("[TB] mid-frame reset restarted, last pixel (%0d,%0d)", last_h, last_v);
        run_until(0, 2);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        test_mode = 1'b1;
        run_until(0, 3);
        step_pixel();
        check("tp_x0", 32'({VGA_R, VGA_G, VGA_B}), 32'h000);
        run_until(BAR_W, 3);
        step_pixel();
        check("tp_bar1", 32'({VGA_R, VGA_G, VGA_B}), 32'h00F);
        run_until(H_VIS - 1, 3);
        step_pixel();
        check("tp_last", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFF);
        run_until(0, 5);
        $display("[TB] test pattern line checked");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
